// File: rtl/keyboard_pkg.sv
// Shared keyboard definitions: Q.20 constants, PS/2 scan-code to note mapping
// and the pythagorean note frequency table.
package keyboard_pkg;

  localparam int                 FREQ_FRAC        = 20;
  localparam logic signed [31:0] FULL_VOLUME      = 32'sd1 <<< FREQ_FRAC;
  localparam logic [31:0]        GROUND_NOTE_FREQ = 32'd55 << FREQ_FRAC;

  typedef logic signed [7:0] note_t;
  localparam note_t NO_NOTE = -8'sd1;

  // Bottom letter row is the low octave and a half, the q-row continues upward.
  function automatic note_t get_note_number(input logic [8:0] code);
    case (code)
      9'h01a: return 8'sd0;   9'h01b: return 8'sd1;   9'h022: return 8'sd2;   9'h023: return 8'sd3;
      9'h021: return 8'sd4;   9'h02a: return 8'sd5;   9'h034: return 8'sd6;   9'h032: return 8'sd7;
      9'h033: return 8'sd8;   9'h031: return 8'sd9;   9'h03b: return 8'sd10;  9'h03a: return 8'sd11;
      9'h041: return 8'sd12;  9'h04b: return 8'sd13;  9'h049: return 8'sd14;  9'h04c: return 8'sd15;
      9'h04a: return 8'sd16;  9'h015: return 8'sd17;  9'h01e: return 8'sd18;  9'h01d: return 8'sd19;
      9'h026: return 8'sd20;  9'h024: return 8'sd21;  9'h02d: return 8'sd22;  9'h02e: return 8'sd23;
      9'h02c: return 8'sd24;  9'h036: return 8'sd25;  9'h035: return 8'sd26;  9'h03d: return 8'sd27;
      9'h03c: return 8'sd28;  9'h043: return 8'sd29;  9'h046: return 8'sd30;  9'h044: return 8'sd31;
      default: return NO_NOTE;
    endcase
  endfunction

  // Each degree is a constant ratio of the ground note; octaves are left shifts.
  function automatic logic [31:0] note_freq(input note_t n);
    logic [7:0]  idx;
    logic [7:0]  deg;
    logic [7:0]  oct;
    logic [31:0] base;
    idx = n;
    deg = idx % 8'd12;
    oct = idx / 8'd12;
    case (deg)
      8'd1:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd256 / 64'd243);
      8'd2:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd9   / 64'd8);
      8'd3:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd32  / 64'd27);
      8'd4:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd81  / 64'd64);
      8'd5:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd4   / 64'd3);
      8'd6:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd729 / 64'd512);
      8'd7:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd3   / 64'd2);
      8'd8:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd128 / 64'd81);
      8'd9:    base = 32'(64'(GROUND_NOTE_FREQ) * 64'd27  / 64'd16);
      8'd10:   base = 32'(64'(GROUND_NOTE_FREQ) * 64'd16  / 64'd9);
      8'd11:   base = 32'(64'(GROUND_NOTE_FREQ) * 64'd243 / 64'd128);
      default: base = GROUND_NOTE_FREQ;
    endcase
    return base << oct;
  endfunction

endpackage

// File: rtl/voice_lru.sv
// Age permutation over the voices: 0 = most recently allocated,
// NUM_VOICES-1 = oldest and first in line to be stolen.
module voice_lru #(
  parameter int NUM_VOICES = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          touch,
  input  logic [$clog2(NUM_VOICES)-1:0] touch_idx,
  output logic [$clog2(NUM_VOICES)-1:0] oldest_idx
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  logic [IDX_W-1:0] age_q [NUM_VOICES];
  logic [IDX_W-1:0] age_d [NUM_VOICES];

  // Only ages younger than the touched voice move, so the set stays a permutation.
  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) age_d[v] = age_q[v];
    if (touch) begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (age_q[v] < age_q[touch_idx]) age_d[v] = age_q[v] + 1'b1;
      end
      age_d[touch_idx] = '0;
    end
  end

  always_comb begin
    oldest_idx = '0;
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (age_q[v] == IDX_W'(NUM_VOICES - 1)) oldest_idx = IDX_W'(v);
    end
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      if (reset) age_q[v] <= IDX_W'(v);
      else       age_q[v] <= age_d[v];
    end
  end

endmodule

// File: rtl/poly_voice_allocator.sv
// PS/2 key events to per-voice note assignments with retrigger, LRU stealing,
// sustain pedal and linear release decay.
module poly_voice_allocator
  import keyboard_pkg::*;
#(
  parameter int         NUM_VOICES   = 8,
  parameter int         TOP_NOTE     = 31,
  parameter int         RELEASE_DIV  = 4096,
  parameter int         RELEASE_STEP = 1 << 12,
  parameter logic [8:0] SUSTAIN_CODE = 9'h029
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [10:0]                 ps2_key,
  output logic [NUM_VOICES-1:0][31:0] frequencies,
  output logic [NUM_VOICES-1:0][31:0] voice_volumes,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES-1:0][7:0]  voice_note,
  output logic                        voice_stolen
);

  localparam int IDX_W = $clog2(NUM_VOICES);
  localparam int DIV_W = (RELEASE_DIV > 1) ? $clog2(RELEASE_DIV) : 1;
  localparam logic signed [31:0] STEP = 32'(RELEASE_STEP);

  function automatic logic signed [31:0] release_dec(input logic signed [31:0] vol);
    return (vol > STEP) ? (vol - STEP) : '0;
  endfunction

  logic                  old_toggle_q, old_toggle_d;
  logic                  evt_vld_q, evt_vld_d;
  logic                  evt_pressed_q, evt_pressed_d;
  logic [8:0]            evt_code_q, evt_code_d;
  note_t                 evt_note_q, evt_note_d;
  logic                  sustain_q, sustain_d;
  logic [DIV_W-1:0]      div_q, div_d;
  logic                  stolen_q, stolen_d;
  logic [31:0]           freq_q [NUM_VOICES];
  logic [31:0]           freq_d [NUM_VOICES];
  logic signed [31:0]    vol_q  [NUM_VOICES];
  logic signed [31:0]    vol_d  [NUM_VOICES];
  note_t                 note_q [NUM_VOICES];
  note_t                 note_d [NUM_VOICES];
  logic [NUM_VOICES-1:0] gate_q, gate_d, held_q, held_d;

  logic             tick, is_sus, note_ok, note_on, note_off, sus_rel;
  logic             match_found, free_found;
  logic [IDX_W-1:0] match_idx, free_idx, alloc_idx, oldest_idx;

  // Stage E: detect the toggle edge and capture the event
  always_comb begin
    old_toggle_d  = ps2_key[10];
    evt_vld_d     = ps2_key[10] != old_toggle_q;
    evt_pressed_d = ps2_key[9];
    evt_code_d    = ps2_key[8:0];
    evt_note_d    = get_note_number(ps2_key[8:0]);
  end

  // Allocation stage: decode the registered event and pick a voice
  always_comb begin
    is_sus    = evt_vld_q && (evt_code_q == SUSTAIN_CODE);
    note_ok   = evt_vld_q && !is_sus && (int'(evt_note_q) >= 0) && (int'(evt_note_q) <= TOP_NOTE);
    note_on   = note_ok && evt_pressed_q;
    note_off  = note_ok && !evt_pressed_q;
    sus_rel   = is_sus && !evt_pressed_q;
    sustain_d = is_sus ? evt_pressed_q : sustain_q;
    match_found = 1'b0;
    match_idx   = '0;
    free_found  = 1'b0;
    free_idx    = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (note_q[v] == evt_note_q) begin
        match_found = 1'b1;
        match_idx   = IDX_W'(v);
      end
      if (!gate_q[v] && (vol_q[v] == '0)) begin
        free_found = 1'b1;
        free_idx   = IDX_W'(v);
      end
    end
    alloc_idx = match_found ? match_idx : (free_found ? free_idx : oldest_idx);
    stolen_d  = note_on && !match_found && !free_found;
  end

  voice_lru #(.NUM_VOICES(NUM_VOICES)) u_lru (
    .clk        (clk),
    .reset      (reset),
    .touch      (note_on),
    .touch_idx  (alloc_idx),
    .oldest_idx (oldest_idx)
  );

  assign tick = (div_q == DIV_W'(RELEASE_DIV - 1));

  // Later assignments win: decay, then pedal/note-off gate changes, then allocation.
  always_comb begin
    div_d = tick ? '0 : div_q + 1'b1;
    for (int v = 0; v < NUM_VOICES; v++) begin
      freq_d[v] = freq_q[v];
      vol_d[v]  = vol_q[v];
      note_d[v] = note_q[v];
      gate_d[v] = gate_q[v];
      held_d[v] = held_q[v];
      if (tick && !gate_q[v] && (vol_q[v] != '0)) begin
        vol_d[v] = release_dec(vol_q[v]);
        if (vol_d[v] == '0) note_d[v] = NO_NOTE;
      end
      if (sus_rel && held_q[v]) begin
        gate_d[v] = 1'b0;
        held_d[v] = 1'b0;
      end
      if (note_off && gate_q[v] && (note_q[v] == evt_note_q)) begin
        if (sustain_q) held_d[v] = 1'b1;
        else           gate_d[v] = 1'b0;
      end
      if (note_on && (alloc_idx == IDX_W'(v))) begin
        freq_d[v] = note_freq(evt_note_q);
        vol_d[v]  = FULL_VOLUME;
        note_d[v] = evt_note_q;
        gate_d[v] = 1'b1;
        held_d[v] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    old_toggle_q <= old_toggle_d;
    if (reset) begin
      evt_vld_q <= 1'b0;
      sustain_q <= 1'b0;
      div_q     <= '0;
      stolen_q  <= 1'b0;
      gate_q    <= '0;
      held_q    <= '0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v] <= '0;
        vol_q[v]  <= '0;
        note_q[v] <= NO_NOTE;
      end
    end else begin
      evt_vld_q <= evt_vld_d;
      sustain_q <= sustain_d;
      div_q     <= div_d;
      stolen_q  <= stolen_d;
      gate_q    <= gate_d;
      held_q    <= held_d;
      for (int v = 0; v < NUM_VOICES; v++) begin
        freq_q[v] <= freq_d[v];
        vol_q[v]  <= vol_d[v];
        note_q[v] <= note_d[v];
      end
    end
  end

  always_ff @(posedge clk) begin
    evt_pressed_q <= evt_pressed_d;
    evt_code_q    <= evt_code_d;
    evt_note_q    <= evt_note_d;
  end

  always_comb begin
    for (int v = 0; v < NUM_VOICES; v++) begin
      frequencies[v]   = freq_q[v];
      voice_volumes[v] = vol_q[v];
      voice_note[v]    = note_q[v];
    end
    voice_gate   = gate_q;
    voice_stolen = stolen_q;
  end

endmodule

// File: tb/tb_poly_voice_allocator.sv
// Bench for poly_voice_allocator: directed scenarios plus randomized key traffic
// compared every cycle against a behavioural voice-bank model.
module tb_poly_voice_allocator;

  localparam int         N    = 4;
  localparam int         RDIV = 4;
  localparam int         STEP = 1 << 18;
  localparam longint     FULL = 1 << 20;
  localparam logic [8:0] SUS  = 9'h029;

  logic                clk = 1'b0;
  logic                reset;
  logic [10:0]         ps2_key;
  logic [N-1:0][31:0]  frequencies;
  logic [N-1:0][31:0]  voice_volumes;
  logic [N-1:0]        voice_gate;
  logic [N-1:0][7:0]   voice_note;
  logic                voice_stolen;

  poly_voice_allocator #(
    .NUM_VOICES(N), .TOP_NOTE(31), .RELEASE_DIV(RDIV), .RELEASE_STEP(STEP), .SUSTAIN_CODE(SUS)
  ) dut (
    .clk(clk), .reset(reset), .ps2_key(ps2_key), .frequencies(frequencies),
    .voice_volumes(voice_volumes), .voice_gate(voice_gate), .voice_note(voice_note),
    .voice_stolen(voice_stolen)
  );

  always #5 clk = ~clk;

  logic [8:0] key_code [32] = '{
    9'h01a, 9'h01b, 9'h022, 9'h023, 9'h021, 9'h02a, 9'h034, 9'h032,
    9'h033, 9'h031, 9'h03b, 9'h03a, 9'h041, 9'h04b, 9'h049, 9'h04c,
    9'h04a, 9'h015, 9'h01e, 9'h01d, 9'h026, 9'h024, 9'h02d, 9'h02e,
    9'h02c, 9'h036, 9'h035, 9'h03d, 9'h03c, 9'h043, 9'h046, 9'h044};
  longint ratio_num [12] = '{1, 256, 9, 32, 81, 4, 729, 3, 128, 27, 16, 243};
  longint ratio_den [12] = '{1, 243, 8, 27, 64, 3, 512, 2, 81, 16, 9, 128};
  longint decay_exp [4]  = '{786432, 524288, 262144, 0};

  function automatic int code_to_note(logic [8:0] c);
    for (int i = 0; i < 32; i++) if (key_code[i] == c) return i;
    return -1;
  endfunction

  function automatic longint note_hz(int n);
    longint b;
    b = (longint'(55) << 20) * ratio_num[n % 12] / ratio_den[n % 12];
    return b << (n / 12);
  endfunction

  // Behavioural model: voice table, recency list (front = most recent), pending event.
  longint     m_freq [N];
  longint     m_vol  [N];
  bit         m_gate [N];
  bit         m_held [N];
  int         m_note [N];
  bit         og     [N];
  int         lru [$];
  bit         m_sus, m_stolen, m_old, m_evt, m_pressed, m_tick;
  logic [8:0] m_code;
  int         m_cyc, m_n, m_alloc;
  bit         model_ready = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      for (int v = 0; v < N; v++) begin
        m_freq[v] = 0; m_vol[v] = 0; m_gate[v] = 0; m_held[v] = 0; m_note[v] = -1;
      end
      m_sus = 0; m_stolen = 0; m_cyc = 0;
      lru.delete();
      for (int v = 0; v < N; v++) lru.push_back(v);
      m_evt = 0;
      model_ready = 1'b1;
    end else begin
      m_tick = (m_cyc % RDIV) == (RDIV - 1);
      m_cyc++;
      m_stolen = 0;
      m_alloc = -1;
      for (int v = 0; v < N; v++) og[v] = m_gate[v];
      if (m_evt) begin
        if (m_code == SUS) begin
          if (!m_pressed)
            for (int v = 0; v < N; v++) if (m_held[v]) begin m_gate[v] = 0; m_held[v] = 0; end
          m_sus = m_pressed;
        end else begin
          m_n = code_to_note(m_code);
          if (m_n >= 0 && m_pressed) begin
            for (int v = 0; v < N; v++) if (m_alloc < 0 && m_note[v] == m_n) m_alloc = v;
            for (int v = 0; v < N; v++) if (m_alloc < 0 && !m_gate[v] && m_vol[v] == 0) m_alloc = v;
            if (m_alloc < 0) begin m_alloc = lru[$]; m_stolen = 1; end
            m_freq[m_alloc] = note_hz(m_n); m_vol[m_alloc] = FULL; m_gate[m_alloc] = 1;
            m_held[m_alloc] = 0; m_note[m_alloc] = m_n;
            for (int i = 0; i < lru.size(); i++) if (lru[i] == m_alloc) begin lru.delete(i); break; end
            lru.push_front(m_alloc);
          end else if (m_n >= 0) begin
            for (int v = 0; v < N; v++)
              if (m_gate[v] && m_note[v] == m_n) begin
                if (m_sus) m_held[v] = 1; else m_gate[v] = 0;
              end
          end
        end
      end
      for (int v = 0; v < N; v++)
        if (m_tick && !og[v] && m_vol[v] > 0 && v != m_alloc) begin
          m_vol[v] = (m_vol[v] > STEP) ? m_vol[v] - STEP : 0;
          if (m_vol[v] == 0) m_note[v] = -1;
        end
      m_evt = ps2_key[10] != m_old;
    end
    m_old = ps2_key[10]; m_pressed = ps2_key[9]; m_code = ps2_key[8:0];
  end

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(string name, longint act, longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  function automatic longint vol_of(int v);  return longint'($signed(voice_volumes[v])); endfunction
  function automatic longint note_of(int v); return longint'($signed(voice_note[v]));    endfunction

  task automatic compare_all();
    for (int v = 0; v < N; v++) begin
      check($sformatf("model_freq[%0d]", v), longint'(frequencies[v]), m_freq[v]);
      check($sformatf("model_vol[%0d]", v),  vol_of(v), m_vol[v]);
      check($sformatf("model_gate[%0d]", v), longint'(voice_gate[v]), longint'(m_gate[v]));
      check($sformatf("model_note[%0d]", v), note_of(v), longint'(m_note[v]));
    end
    check("model_stolen", longint'(voice_stolen), longint'(m_stolen));
  endtask

  task automatic step();
    @(negedge clk);
    if (model_ready) compare_all();
  endtask

  task automatic idle(int n);
    repeat (n) step();
  endtask

  task automatic send(bit pressed, logic [8:0] code);
    step();
    ps2_key = {~ps2_key[10], pressed, code};
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(3);
    reset = 1'b0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    longint   prev;
    longint   chg_v [$];
    int       chg_t [$];
    int       r;
    logic [8:0] code;
    reset = 1'b1;
    ps2_key = '0;
    idle(3);
    check("rst_gate", longint'(voice_gate), 0);
    check("rst_note0", note_of(0), -1);
    check("rst_vol3", vol_of(3), 0);
    check("rst_stolen", longint'(voice_stolen), 0);
    reset = 1'b0;

    // Single press, plus a couple of table pins
    send(1, key_code[0]); idle(2);
    check("t1_freq0", longint'(frequencies[0]), 57671680);
    check("t1_vol0", vol_of(0), 1048576);
    check("t1_gate0", longint'(voice_gate[0]), 1);
    check("t1_note0", note_of(0), 0);
    check("t1_note1_free", note_of(1), -1);
    send(1, key_code[7]); idle(2);
    check("t1_freq_n7", longint'(frequencies[1]), 86507520);
    send(1, key_code[12]); idle(2);
    check("t1_freq_n12", longint'(frequencies[2]), 115343360);

    // Same-note retrigger
    do_reset();
    send(1, key_code[0]); step(); send(1, key_code[0]); idle(2);
    check("t2_gate0", longint'(voice_gate[0]), 1);
    check("t2_note0", note_of(0), 0);
    check("t2_gate1", longint'(voice_gate[1]), 0);
    check("t2_note1", note_of(1), -1);

    // Steal the oldest voice
    do_reset();
    for (int i = 0; i < N; i++) send(1, key_code[i]);
    send(1, key_code[N]);
    step(); check("t3_stolen_before", longint'(voice_stolen), 0);
    step(); check("t3_stolen_pulse", longint'(voice_stolen), 1);
    check("t3_note0", note_of(0), N);
    step(); check("t3_stolen_after", longint'(voice_stolen), 0);

    // Release decay
    do_reset();
    send(1, key_code[0]); idle(3); send(0, key_code[0]); idle(2);
    check("t4_gate_off", longint'(voice_gate[0]), 0);
    check("t4_vol_full", vol_of(0), FULL);
    prev = FULL;
    for (int c = 1; c <= 24; c++) begin
      step();
      if (vol_of(0) != prev) begin chg_v.push_back(vol_of(0)); chg_t.push_back(c); prev = vol_of(0); end
    end
    check("t4_nsteps", chg_v.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("t4_step%0d", i), (i < chg_v.size()) ? chg_v[i] : -99, decay_exp[i]);
    for (int i = 1; i < 4; i++)
      check($sformatf("t4_gap%0d", i), (i < chg_t.size()) ? longint'(chg_t[i] - chg_t[i-1]) : -99, RDIV);
    check("t4_note_free", note_of(0), -1);

    // Sustain pedal
    do_reset();
    send(1, SUS); send(1, key_code[3]); send(0, key_code[3]); idle(6);
    check("t5_gate_held", longint'(voice_gate[0]), 1);
    check("t5_vol_held", vol_of(0), FULL);
    send(0, SUS);
    step(); check("t5_gate_k1", longint'(voice_gate[0]), 1);
    step(); check("t5_gate_drop", longint'(voice_gate[0]), 0);
    idle(20);
    check("t5_note_free", note_of(0), -1);

    // Reset mid-release with a pending toggle
    do_reset();
    send(1, key_code[5]); idle(3); send(0, key_code[5]); idle(4);
    reset = 1'b1;
    ps2_key = {~ps2_key[10], 1'b1, key_code[9]};
    idle(2);
    reset = 1'b0;
    idle(4);
    check("t6_gate", longint'(voice_gate), 0);
    check("t6_vol0", vol_of(0), 0);
    check("t6_note0", note_of(0), -1);
    check("t6_freq0", longint'(frequencies[0]), 0);

    // Randomized traffic
    do_reset();
    for (int e = 0; e < 1500; e++) begin
      r = $urandom_range(0, 99);
      if (r < 7)       code = SUS;
      else if (r < 10) code = ($urandom_range(0, 1) == 0) ? 9'h076 : 9'h11a;
      else if (r < 80) code = key_code[$urandom_range(0, 7)];
      else             code = key_code[$urandom_range(0, 31)];
      send($urandom_range(0, 99) < 55, code);
      idle($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) idle(25);
    end
    idle(40);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
